seq_scan_controller: RTL and testbench
======================================

// Module: seq_scan_controller
// PURPOSE
//   Sequencer/scheduler that feeds a serial pattern detector from a word stream.
//   - Accepts DATA_W-bit words over a valid/ready handshake.
//   - Serializes each word MSB first onto bit_out (the detector's w input).
//   - Runs a registered PAT_W-bit detector with overlap allowed.
//   - Counts matches over a job of num_words words, then pulses done.
//   - Sits between a word source (UART/FIFO) and status logic / LEDs.
// PARAMETERS
//   DATA_W   8        word width, bits serialized per word
//   PAT_W    4        pattern length in bits
//   PATTERN  4'b1001  pattern to detect; oldest bit is the MSB
//   CNT_W    8        width of match_count
// PORTS
//   clk          in   1       rising-edge clock
//   reset        in   1       asynchronous, active-high reset
//   start        in   1       job start pulse; honoured only in IDLE
//   num_words    in   8       words in job; sampled on accepted start
//   in_valid     in   1       source has a word
//   in_data      in   DATA_W  word; sampled on in_valid & in_ready
//   in_ready     out  1       1 only in LOAD state (combinational from state)
//   bit_out      out  1       bit being serialized; 0 outside SHIFT
//   busy         out  1       1 in any state other than IDLE
//   match_pulse  out  1       1-cycle pulse per detected match
//   match_count  out  CNT_W   matches in current/last job; held until next start
//   done         out  1       1-cycle pulse at end of job
// BEHAVIOUR
//   Reset (async, any state, including mid-shift):
//     - state = IDLE; history, fill counter and word/bit counters cleared.
//     - All outputs are 0; match_count = 0.
//   FSM: IDLE -> LOAD -> SHIFT -> (LOAD | FINISH) -> IDLE
//     IDLE:
//       - On start: latch num_words, clear history/fill/match_count.
//       - If num_words == 0, go to FINISH; otherwise go to LOAD.
//       - start outside IDLE is ignored.
//     LOAD:
//       - in_ready = 1.
//       - On in_valid: latch in_data into the shift register, bit counter = 0,
//         go to SHIFT.
//       - in_valid low: stay in LOAD indefinitely; no bits are emitted.
//     SHIFT:
//       - One bit per cycle, MSB first; bit_out = sreg[DATA_W-1].
//       - At the edge: hist <= {hist[PAT_W-2:0], bit_out};
//         fill <= min(fill+1, PAT_W).
//       - After DATA_W cycles, decrement words left.
//       - If words left is 0, go to FINISH; otherwise go to LOAD.
//     FINISH:
//       - done = 1 for exactly one cycle, then IDLE.
//   Detector:
//     - At the edge ending a SHIFT cycle:
//       match_pulse <= (fill_next == PAT_W) && (hist_next == PATTERN).
//     - match_count increments at the same edge, so the pulse shows one cycle
//       after the completing bit.
//     - Overlap is allowed: the history is not cleared on a match.
//     - The history persists across words, so patterns may span a word
//       boundary. It is cleared only on an accepted start or on reset.
//     - A match on the job's last bit shows match_pulse in the FINISH cycle.
//       match_count in the done cycle includes it.
//   Throughput:
//     - DATA_W + 1 cycles per word when in_valid is held high.
// CONFIGURATION
//   SEQ_SCAN_SAT_EN
//     - Defined: match_count saturates at 2^CNT_W-1. match_pulse still pulses
//       on every match.
//     - Undefined: match_count wraps modulo 2^CNT_W.
// TESTING
//   1. start, num_words=1, in_data=8'h99 -> bit_out=1,0,0,1,1,0,0,1;
//      match_pulse after bits 4 and 8; done with match_count=2.
//   2. num_words=2, words 8'h01 then 8'h20 -> one match spanning the boundary
//      (bits 8..11); match_count=1 at done.
//   3. in_data=8'h49 (01001001) -> overlapping matches ending at bits 5 and 8;
//      match_count=2.
//   4. num_words=0 -> done high in the cycle after start; match_count=0;
//      in_ready never asserted.
//   5. In LOAD, hold in_valid low 5 cycles -> in_ready=1 throughout,
//      bit_out=0, no state change. Then give in_valid=1 with 8'h99 ->
//      same result as test 1.
//   6. CNT_W=2, num_words=2, 8'h99 twice (4 matches) -> match_count=3 with
//      SEQ_SCAN_SAT_EN defined, 0 without. Also: assert reset mid-SHIFT ->
//      all outputs 0 immediately; a later job counts from 0.

Source files
------------

// File: rtl/seq_scan_controller.sv
// seq_scan_controller
//   Takes words from a valid/ready source, shifts each one out MSB first on
//   bit_out and runs an overlapping PAT_W-bit pattern detector on that bit
//   stream. A job covers num_words words and ends with a one-cycle done pulse.
//   Matches are counted in match_count, which holds its value until the next
//   accepted start.
//
//   Configuration macro: SEQ_SCAN_SAT_EN
//     defined   -> match_count saturates at all-ones
//     undefined -> match_count wraps modulo 2^CNT_W
module seq_scan_controller #(
   parameter int               DATA_W  = 8,
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1001,
   parameter int               CNT_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        num_words,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              bit_out,
   output logic              busy,
   output logic              match_pulse,
   output logic [CNT_W-1:0]  match_count,
   output logic              done
);

   // Counter widths: the bit counter indexes one word, the fill counter
   // must be able to hold the value PAT_W itself.
   localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int FILL_W = $clog2(PAT_W + 1);

   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_FINISH
   } state_t;

   state_t state;
   state_t state_next;

   // Datapath registers
   logic [DATA_W-1:0] sreg;
   logic [BIT_W-1:0]  bit_cnt;
   logic [7:0]        words_left;

   // Detector registers
   logic [PAT_W-1:0]  hist;
   logic [FILL_W-1:0] fill;

   // Decoded control strobes from the FSM
   logic job_start;
   logic word_take;
   logic shift_en;

   // Detector look-ahead values for the bit leaving this cycle
   logic [PAT_W-1:0]  hist_next;
   logic [FILL_W-1:0] fill_next;
   logic              match_hit;
   logic [CNT_W-1:0]  count_inc;

   // Outputs decoded directly from the current state.
   assign in_ready = (state == S_LOAD);
   assign busy     = (state != S_IDLE);
   assign done     = (state == S_FINISH);
   assign bit_out  = (state == S_SHIFT) && sreg[DATA_W-1];

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode and control strobes.
   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_next = state;
      job_start  = 1'b0;
      word_take  = 1'b0;
      shift_en   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               job_start  = 1'b1;
               state_next = (num_words == 8'd0) ? S_FINISH : S_LOAD;
            end
         end
         S_LOAD: begin
            if (in_valid) begin
               word_take  = 1'b1;
               state_next = S_SHIFT;
            end
         end
         S_SHIFT: begin
            shift_en = 1'b1;
            if (bit_cnt == BIT_LAST) begin
               // words_left is decremented at this edge; a value of one
               // means this was the final word of the job.
               state_next = (words_left == 8'd1) ? S_FINISH : S_LOAD;
            end
         end
         S_FINISH: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Word latch, serializer and word/bit bookkeeping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sreg       <= '0;
         bit_cnt    <= '0;
         words_left <= '0;
      end else begin
         if (job_start) begin
            words_left <= num_words;
         end
         if (word_take) begin
            sreg    <= in_data;
            bit_cnt <= '0;
         end else if (shift_en) begin
            sreg    <= {sreg[DATA_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (bit_cnt == BIT_LAST) begin
               words_left <= words_left - 8'd1;
            end
         end
      end
   end

   // Detector look-ahead: history and fill as they will be after this bit,
   // plus the next count value for a match.
   always_comb begin
      hist_next = {hist[PAT_W-2:0], bit_out};
      fill_next = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
      match_hit = shift_en && (fill_next == FILL_FULL) && (hist_next == PATTERN);
`ifdef SEQ_SCAN_SAT_EN
      count_inc = (match_count == CNT_MAX) ? match_count : match_count + CNT_W'(1);
`else
      count_inc = match_count + CNT_W'(1);
`endif
   end

   // Detector state: history spans word boundaries and is only cleared at
   // job start, so patterns straddling two words are still seen.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist        <= '0;
         fill        <= '0;
         match_pulse <= 1'b0;
         match_count <= '0;
      end else begin
         match_pulse <= match_hit;
         if (job_start) begin
            hist        <= '0;
            fill        <= '0;
            match_count <= '0;
         end else if (shift_en) begin
            hist <= hist_next;
            fill <= fill_next;
            if (match_hit) begin
               match_count <= count_inc;
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_scan_controller.sv
// Self-checking bench for seq_scan_controller.
//   Two instances share all inputs: one with CNT_W=8, one with CNT_W=2 to
//   exercise count wrap/saturation. A reference detector model pushes the
//   expected bit stream and match flags into queues as words are driven; a
//   per-cycle monitor pops and compares them while the DUT is shifting.
module tb_seq_scan_controller;

   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [7:0]        num_words;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;

   logic              in_ready, bit_out, busy, match_pulse, done;
   logic [7:0]        match_count;
   logic              in_ready2, bit_out2, busy2, match_pulse2, done2;
   logic [1:0]        match_count2;

   int checks = 0;
   int errors = 0;

   // Scoreboard queues and reference detector state
   logic       exp_bit_q[$];
   logic       exp_hit_q[$];
   logic [3:0] m_hist;
   int         m_fill;
   logic       pend_pulse;

   seq_scan_controller #(.DATA_W(8), .PAT_W(4), .PATTERN(4'b1001), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .num_words(num_words),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .bit_out(bit_out), .busy(busy), .match_pulse(match_pulse),
      .match_count(match_count), .done(done)
   );

   seq_scan_controller #(.DATA_W(8), .PAT_W(4), .PATTERN(4'b1001), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .start(start), .num_words(num_words),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
      .bit_out(bit_out2), .busy(busy2), .match_pulse(match_pulse2),
      .match_count(match_count2), .done(done2)
   );

   always #5 clk = ~clk;

   task automatic model_clear();
      m_hist     = 4'b0000;
      m_fill     = 0;
      pend_pulse = 1'b0;
      exp_bit_q.delete();
      exp_hit_q.delete();
   endtask

   // Reference detector: walk the word MSB first, record each bit and
   // whether the 4-bit window ending on it is a full-history 1001.
   task automatic push_word(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) begin
         m_hist = {m_hist[2:0], w[i]};
         if (m_fill < 4) m_fill++;
         exp_bit_q.push_back(w[i]);
         exp_hit_q.push_back((m_fill == 4) && (m_hist == 4'b1001));
      end
   endtask

   // Per-cycle monitor, called at the falling edge.
   task automatic cycle_check();
      logic shifting;
      logic eb;
      logic want_pulse;
      want_pulse = pend_pulse;
      pend_pulse = 1'b0;
      shifting   = busy && !in_ready && !done;
      checks++;
      if (match_pulse !== want_pulse) begin
         errors++;
         $display("FAIL match_pulse t=%0t got %b want %b", $time, match_pulse, want_pulse);
      end
      checks++;
      if (match_pulse2 !== want_pulse) begin
         errors++;
         $display("FAIL match_pulse_cnt2 t=%0t got %b want %b", $time, match_pulse2, want_pulse);
      end
      if (shifting) begin
         checks++;
         if (exp_bit_q.size() == 0) begin
            errors++;
            $display("FAIL shift_unexpected t=%0t got shifting want no bits pending", $time);
         end else begin
            eb         = exp_bit_q.pop_front();
            pend_pulse = exp_hit_q.pop_front();
            if (bit_out !== eb) begin
               errors++;
               $display("FAIL bit_out t=%0t got %b want %b", $time, bit_out, eb);
            end
         end
      end else begin
         checks++;
         if (bit_out !== 1'b0) begin
            errors++;
            $display("FAIL bit_out_idle t=%0t got %b want 0", $time, bit_out);
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      cycle_check();
   endtask

   // Run one job of up to two words; stall cycles are inserted in LOAD
   // before the first word.
   task automatic run_job(input string name, input int n, input logic [7:0] w0,
                          input logic [7:0] w1, input int stall,
                          input int exp8, input int exp2);
      model_clear();
      start     = 1'b1;
      num_words = 8'(n);
      step();
      start     = 1'b0;
      for (int k = 0; k < n; k++) begin
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_in_ready word %0d got %b want 1", name, k, in_ready);
         end
         if (k == 0) begin
            for (int s = 0; s < stall; s++) begin
               step();
               checks++;
               if (in_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                  errors++;
                  $display("FAIL %s_stall cycle %0d got ready=%b busy=%b done=%b want 1 1 0",
                           name, s, in_ready, busy, done);
               end
            end
         end
         in_valid = 1'b1;
         in_data  = (k == 0) ? w0 : w1;
         push_word(in_data);
         step();
         in_valid = 1'b0;
         in_data  = '0;
         repeat (DATA_W - 1) step();
         step();
      end
      checks++;
      if (done !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s_done got done=%b ready=%b want 1 0", name, done, in_ready);
      end
      checks++;
      if (match_count !== 8'(exp8)) begin
         errors++;
         $display("FAIL %s_count got %0d want %0d", name, match_count, exp8);
      end
      checks++;
      if (match_count2 !== 2'(exp2)) begin
         errors++;
         $display("FAIL %s_count_cnt2 got %0d want %0d", name, match_count2, exp2);
      end
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s_idle got done=%b busy=%b ready=%b want 0 0 0", name, done, busy, in_ready);
      end
      checks++;
      if (match_count !== 8'(exp8)) begin
         errors++;
         $display("FAIL %s_count_held got %0d want %0d", name, match_count, exp8);
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({in_ready, bit_out, busy, match_pulse, done} !== 5'b0 || match_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_outputs got rdy=%b bit=%b busy=%b mp=%b done=%b cnt=%0d want all 0",
                  in_ready, bit_out, busy, match_pulse, done, match_count);
      end
      @(negedge clk);
      reset = 1'b0;
      step();
   endtask

   task automatic test_single_word();
      run_job("single_99", 1, 8'h99, 8'h00, 0, 2, 2);
   endtask

   task automatic test_boundary_span();
      run_job("span_01_20", 2, 8'h01, 8'h20, 0, 1, 1);
   endtask

   task automatic test_overlap();
      run_job("overlap_49", 1, 8'h49, 8'h00, 0, 2, 2);
   endtask

   task automatic test_zero_words();
      run_job("zero_words", 0, 8'h00, 8'h00, 0, 0, 0);
   endtask

   task automatic test_load_stall();
      run_job("stall_99", 1, 8'h99, 8'h00, 5, 2, 2);
   endtask

   task automatic test_back_to_back_count();
`ifdef SEQ_SCAN_SAT_EN
      run_job("b2b_99_99", 2, 8'h99, 8'h99, 0, 4, 3);
`else
      run_job("b2b_99_99", 2, 8'h99, 8'h99, 0, 4, 0);
`endif
   endtask

   task automatic test_reset_mid_shift();
      model_clear();
      start     = 1'b1;
      num_words = 8'd1;
      step();
      start     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h99;
      push_word(in_data);
      step();
      in_valid  = 1'b0;
      in_data   = '0;
      step();
      step();
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({in_ready, bit_out, busy, match_pulse, done} !== 5'b0 || match_count !== 8'd0
          || match_count2 !== 2'd0) begin
         errors++;
         $display("FAIL reset_mid_shift got rdy=%b bit=%b busy=%b mp=%b done=%b cnt=%0d want all 0",
                  in_ready, bit_out, busy, match_pulse, done, match_count);
      end
      @(negedge clk);
      reset = 1'b0;
      model_clear();
      step();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_shift_idle got busy=%b want 0", busy);
      end
      run_job("after_reset_99", 1, 8'h99, 8'h00, 0, 2, 2);
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      num_words = 8'd0;
      in_valid  = 1'b0;
      in_data   = '0;
      model_clear();
      test_reset();
      test_single_word();
      test_boundary_span();
      test_overlap();
      test_zero_words();
      test_load_stall();
      test_back_to_back_count();
      test_reset_mid_shift();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
